// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-digit stopwatch/timer counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Any nibble outside the decimal range is pinned to 9.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Combinational next-value cell for one BCD digit; step_in/step_out form the
// carry (up) or borrow (down) ripple chain between neighbouring digits.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t d_next,
  output logic       step_out
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    d_next   = d;
    step_out = 1'b0;
    if (step_in) begin
      if (up) begin
        if (d >= BCD_MAX) begin
          d_next   = BCD_MIN;
          step_out = 1'b1;
        end else begin
          d_next = d + 4'd1;
        end
      end else begin
        if (d == BCD_MIN) begin
          d_next   = BCD_MAX;
          step_out = 1'b1;
        end else begin
          d_next = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// DIGITS-wide BCD up/down counter with clear, clamped load, wrap/saturate,
// terminal-count pulse and a lap-hold display register.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                hold,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] disp,
  output logic                tc
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    r_count;
  logic [W-1:0]    r_disp;
  logic            r_tc;

  logic [W-1:0]    w_stepped;
  logic [W-1:0]    w_load_clamped;
  logic [W-1:0]    w_count_next;
  logic [DIGITS:0] w_step;
  logic            w_at_bound;
  logic            w_tc_next;

  // Digit 0 always receives a step request; the chain's final carry/borrow
  // out is high exactly when every digit sits at the boundary for 'up'.
  assign w_step[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .d        (r_count[4*k +: 4]),
      .step_in  (w_step[k]),
      .up       (up),
      .d_next   (w_stepped[4*k +: 4]),
      .step_out (w_step[k+1])
    );
    assign w_load_clamped[4*k +: 4] = bcd_clamp(load_val[4*k +: 4]);
  end

  assign w_at_bound = w_step[DIGITS];

  always_comb begin
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    if (clear) begin
      w_count_next = '0;
    end else if (load) begin
      w_count_next = w_load_clamped;
    end else if (en) begin
      w_tc_next = w_at_bound;
      // At the boundary the ripple result is already the wrapped value.
      if (!w_at_bound || WRAP) begin
        w_count_next = w_stepped;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_disp  <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
      if (!hold) begin
        r_disp <= w_count_next;
      end
    end
  end

  assign count = r_count;
  assign disp  = r_disp;
  assign tc    = r_tc;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a wrapping and a saturating instance share stimulus
// and are compared every cycle against a decimal-integer model.
module tb_bcd_counter_n;

  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst, en, up, clear, load, hold;
  logic [15:0] load_val;

  logic [15:0] count_w, disp_w, count_s, disp_s;
  logic        tc_w, tc_s;

  int n_checks = 0;
  int n_fail   = 0;

  int m_val  [2];
  int m_disp [2];
  bit m_tc   [2];
  bit m_valid = 1'b0;

  always #10 clk = ~clk;

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .hold(hold), .count(count_w), .disp(disp_w), .tc(tc_w)
  );

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .hold(hold), .count(count_s), .disp(disp_s), .tc(tc_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(input logic [15:0] b);
    int v;
    int scale;
    int nib;
    v     = 0;
    scale = 1;
    for (int k = 0; k < 4; k++) begin
      nib   = int'(b[4*k +: 4]);
      v     = v + ((nib > 9) ? 9 : nib) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  // Model: the count is a plain integer 0..9999.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_val[i]  = 0;
        m_disp[i] = 0;
        m_tc[i]   = 1'b0;
      end else begin
        m_tc[i] = 1'b0;
        if (clear) begin
          m_val[i] = 0;
        end else if (load) begin
          m_val[i] = from_bcd_clamped(load_val);
        end else if (en) begin
          if (up) begin
            if (m_val[i] == MAXV) begin
              m_tc[i]  = 1'b1;
              m_val[i] = (i == 0) ? 0 : MAXV;
            end else begin
              m_val[i] = m_val[i] + 1;
            end
          end else begin
            if (m_val[i] == 0) begin
              m_tc[i]  = 1'b1;
              m_val[i] = (i == 0) ? MAXV : 0;
            end else begin
              m_val[i] = m_val[i] - 1;
            end
          end
        end
        if (!hold) m_disp[i] = m_val[i];
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_count_wrap", 32'(count_w), 32'(to_bcd(m_val[0])));
      check("model_disp_wrap",  32'(disp_w),  32'(to_bcd(m_disp[0])));
      check("model_tc_wrap",    32'(tc_w),    32'(m_tc[0]));
      check("model_count_sat",  32'(count_s), 32'(to_bcd(m_val[1])));
      check("model_disp_sat",   32'(disp_s),  32'(to_bcd(m_disp[1])));
      check("model_tc_sat",     32'(tc_s),    32'(m_tc[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; hold = 1'b0;
    load_val = 16'h0000;
    tick();
    check("reset_count", 32'(count_w), 32'h0000);
    check("reset_disp",  32'(disp_s),  32'h0000);
    check("reset_tc",    32'(tc_w),    32'h0);
    rst = 1'b0;

    // 12 up steps from zero
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("step_tc", 32'(tc_w), 32'h0);
    end
    check("step12_count", 32'(count_w), 32'h0012);
    check("step12_disp",  32'(disp_w),  32'h0012);

    // Up across MAX
    do_load(16'h9998);
    en = 1'b1; up = 1'b1;
    tick();
    check("upwrap_9999", 32'(count_w), 32'h9999);
    check("upwrap_tc0",  32'(tc_w),    32'h0);
    tick();
    check("upwrap_0000", 32'(count_w), 32'h0000);
    check("upwrap_tc1",  32'(tc_w),    32'h1);
    check("upsat_9999",  32'(count_s), 32'h9999);
    check("upsat_tc1",   32'(tc_s),    32'h1);
    tick();
    check("upsat_held",  32'(count_s), 32'h9999);
    check("upsat_tc_hi", 32'(tc_s),    32'h1);
    en = 1'b0;
    tick();
    check("idle_tc0",    32'(tc_s),    32'h0);

    // Down into MIN
    do_load(16'h0001);
    en = 1'b1; up = 1'b0;
    tick();
    check("dn_sat_c0", 32'(count_s), 32'h0000);
    check("dn_sat_t0", 32'(tc_s),    32'h0);
    tick();
    check("dn_sat_c1", 32'(count_s), 32'h0000);
    check("dn_sat_t1", 32'(tc_s),    32'h1);
    check("dn_wrap_c", 32'(count_w), 32'h9999);
    tick();
    check("dn_sat_c2", 32'(count_s), 32'h0000);
    check("dn_sat_t2", 32'(tc_s),    32'h1);
    check("dn_wrap_2", 32'(count_w), 32'h9998);

    // Load clamp beats en; clear beats load
    load = 1'b1; load_val = 16'hF3A7; clear = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("load_clamp", 32'(count_w), 32'h9397);
    check("load_tc",    32'(tc_w),    32'h0);
    clear = 1'b1;
    tick();
    check("clear_prio", 32'(count_s), 32'h0000);
    clear = 1'b0; load = 1'b0;

    // Lap hold
    do_load(16'h0100);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("lap_start", 32'(count_w), 32'h0105);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lap_frozen", 32'(disp_w), 32'h0105);
    end
    check("lap_running", 32'(count_w), 32'h0110);
    hold = 1'b0;
    tick();
    check("lap_release", 32'(disp_w), 32'h0111);

    // Reset mid-run overrides hold and en
    do_load(16'h4321);
    check("pre_rst", 32'(count_w), 32'h4321);
    hold = 1'b1; en = 1'b1; rst = 1'b1;
    tick();
    check("rst_count", 32'(count_w), 32'h0000);
    check("rst_disp",  32'(disp_w),  32'h0000);
    check("rst_tc",    32'(tc_w),    32'h0);
    rst = 1'b0; hold = 1'b0; en = 1'b0;
    tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
